// File: rtl/mem_access_unit_if.sv
// Bundle of the CPU request/response handshake and the memory-bus signals
// seen by the load/store unit. The "slave" side is the unit itself; the
// "master" side is whatever drives requests and returns bus read data.
interface mem_access_unit_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;

  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  logic             bus_mem_read;
  logic             bus_mem_write;
  logic [WIDTH-1:0] bus_addr;
  logic [WIDTH-1:0] bus_wdata;
  logic [3:0]       bus_byteen;
  logic [WIDTH-1:0] bus_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           bus_mem_read, bus_mem_write, bus_addr, bus_wdata, bus_byteen
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           bus_mem_read, bus_mem_write, bus_addr, bus_wdata, bus_byteen
  );
endinterface

// File: rtl/mem_access_unit.sv
// RV32I load/store unit: accepts one CPU access at a time, checks it for
// legality and alignment, drives a lane-steered transaction on the memory
// bus, waits out the read latency and returns one response pulse.
module mem_access_unit #(
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave io
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY);

  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic       lat_write;
  logic [2:0] lat_funct3;

  logic             req_legal;
  logic             req_misal;
  logic [3:0]       req_byteen;
  logic [WIDTH-1:0] req_steer;
  logic             accept;
  logic             accept_ok;
  logic             accept_err;
  logic             access_done;

  logic [WIDTH-1:0] ld_byte_sh;
  logic [WIDTH-1:0] ld_half_sh;
  logic [WIDTH-1:0] ld_data;

  // Ready only while idle; forced low for as long as reset is held.
  assign io.req_ready = (state == IDLE) && !rst;

  assign accept      = io.req_valid && io.req_ready;
  assign accept_ok   = accept && req_legal && !req_misal;
  assign accept_err  = accept && !(req_legal && !req_misal);
  assign access_done = (state == ACCESS) && (lat_write || (cnt == LAST_CNT));

  // Decode the incoming request: legality, alignment, lanes and store data.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can leave a value held (a latch).
    req_legal  = 1'b0;
    req_misal  = 1'b0;
    req_byteen = 4'b1111;
    req_steer  = io.req_wdata;

    unique case ({io.req_write, io.req_funct3})
      4'b0_000, 4'b0_001, 4'b0_010, 4'b0_100, 4'b0_101,
      4'b1_000, 4'b1_001, 4'b1_010: req_legal = 1'b1;
      default:                      req_legal = 1'b0;
    endcase

    unique case (io.req_funct3[1:0])
      2'b00: begin
        req_byteen = 4'b0001 << io.req_addr[1:0];
        req_steer  = {4{io.req_wdata[7:0]}};
      end
      2'b01: begin
        req_byteen = 4'b0011 << {io.req_addr[1], 1'b0};
        req_steer  = {2{io.req_wdata[15:0]}};
        req_misal  = io.req_addr[0];
      end
      default: begin
        req_byteen = 4'b1111;
        req_steer  = io.req_wdata;
        req_misal  = (io.req_addr[1:0] != 2'b00);
      end
    endcase
  end

  // Extract and extend the addressed lane of the returned read word.
  always_comb begin
    ld_byte_sh = io.bus_rdata >> {io.bus_addr[1:0], 3'b000};
    ld_half_sh = io.bus_rdata >> {io.bus_addr[1], 4'b0000};
    ld_data    = io.bus_rdata;
    unique case (lat_funct3)
      3'b000:  ld_data = {{24{ld_byte_sh[7]}}, ld_byte_sh[7:0]};
      3'b001:  ld_data = {{16{ld_half_sh[15]}}, ld_half_sh[15:0]};
      3'b100:  ld_data = {24'd0, ld_byte_sh[7:0]};
      3'b101:  ld_data = {16'd0, ld_half_sh[15:0]};
      default: ld_data = io.bus_rdata;
    endcase
  end

  // Next-state logic: error requests skip straight to the response.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept_ok) begin
          state_nx = ACCESS;
          cnt_nx   = 3'd0;
        end else if (accept_err) begin
          state_nx = RESP;
        end
      end
      ACCESS: begin
        if (access_done) state_nx = RESP;
        else             cnt_nx   = cnt + 3'd1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and access-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the values from before the edge, independent of block order.
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Registered bus drive, request latch and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write        <= 1'b0;
      lat_funct3       <= 3'd0;
      io.bus_mem_read  <= 1'b0;
      io.bus_mem_write <= 1'b0;
      io.bus_addr      <= '0;
      io.bus_wdata     <= '0;
      io.bus_byteen    <= 4'd0;
      io.resp_valid    <= 1'b0;
      io.resp_err      <= 1'b0;
      io.resp_rdata    <= '0;
    end else begin
      io.resp_valid <= (state_nx == RESP);
      io.resp_err   <= accept_err;
      io.resp_rdata <= '0;

      if (accept) begin
        lat_write  <= io.req_write;
        lat_funct3 <= io.req_funct3;
      end

      if (accept_ok) begin
        io.bus_mem_read  <= !io.req_write;
        io.bus_mem_write <= io.req_write;
        io.bus_addr      <= io.req_addr;
        io.bus_byteen    <= req_byteen;
        io.bus_wdata     <= io.req_write ? req_steer : '0;
      end else if (access_done) begin
        io.bus_mem_read  <= 1'b0;
        io.bus_mem_write <= 1'b0;
        io.bus_addr      <= '0;
        io.bus_byteen    <= 4'd0;
        io.bus_wdata     <= '0;
      end

      // Read data is valid on the final access cycle only.
      if (access_done && !lat_write) io.resp_rdata <= ld_data;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store unit that turns CPU data-access requests (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW) into transactions on the unified memory bus.
- Drives the bus's mem_read/mem_write/addr/data/byteen inputs and consumes its read data.
- Handles byte-lane steering, write-data replication, read extraction with sign/zero extension, misalignment/illegal-op detection and a multi-cycle read wait.
- Sits between the execute stage and the memory bus.

Parameters:
WIDTH, 32, data/address width (byte-lane logic is defined for 32 only)
READ_LATENCY, 1, cycles from bus_mem_read/addr stable until bus_rdata is valid (1..7)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  CPU request present
req_ready  output  1  unit can accept a request (high only in IDLE and rst low)
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  WIDTH  byte address
req_wdata  input  WIDTH  store data, right-aligned
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  WIDTH  extended load data (0 for stores and errors)
resp_err  output  1  misaligned or illegal funct3; valid with resp_valid
bus_mem_read  output  1  to memory bus mem_read
bus_mem_write  output  1  to memory bus mem_write
bus_addr  output  WIDTH  to memory bus addr_in (full byte address)
bus_wdata  output  WIDTH  to memory bus data_in, lane-steered
bus_byteen  output  4  to memory bus byteen
bus_rdata  input  WIDTH  from memory bus mem_data_out

Behaviour:
- Reset value of every output is 0: req_ready, resp_valid, resp_rdata, resp_err, bus_mem_read, bus_mem_write, bus_addr, bus_wdata and bus_byteen. State is IDLE and the latency counter is 0.
- Reset asserted mid-operation aborts the transaction immediately (asynchronous). Strobes drop in the same instant and no response is issued.
- FSM states:
  - IDLE -> ACCESS on a valid, legal handshake (req_valid & req_ready).
  - IDLE -> RESP on an illegal or misaligned handshake.
  - ACCESS -> RESP after 1 cycle for a store, or after READ_LATENCY+1 cycles for a load.
  - RESP -> IDLE unconditionally.
- Accept: on req_valid & req_ready, latch write, funct3, addr and wdata. req_valid outside IDLE is ignored. There is no queueing.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is illegal.
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
- Error path: no bus strobe is ever asserted. Response arrives the cycle after accept with resp_err=1 and resp_rdata=0.
- Bus outputs are registered from the latched request and are held stable for all ACCESS cycles.
  - bus_mem_write is high for exactly 1 cycle on stores.
  - bus_mem_read is high for all READ_LATENCY+1 cycles on loads.
  - Both strobes are 0 in IDLE and RESP. They are never high together.
- Byteen:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 4'b0011 << {addr[1],1'b0}.
  - Word: 4'b1111.
  - Driven identically for loads.
- bus_wdata: byte replicated into all 4 lanes; half replicated into both halves; word passed through.
- Load capture: bus_rdata is sampled on the last ACCESS cycle.
  - The addressed byte is rdata >> (8*addr[1:0]); the addressed half is rdata >> (16*addr[1]).
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Response: resp_valid is high exactly one cycle (RESP). resp_rdata and resp_err are valid only then and are 0 otherwise.
- Latency from accept cycle T:
  - Store: resp_valid at T+2.
  - Load: resp_valid at T+2+READ_LATENCY.
  - Error: resp_valid at T+1.
- Next accept is possible the cycle after RESP.
- Address wrap: none. bus_addr passes through unmodified, and out-of-map decode is the bus's job.

Test Plan:
- Reset during load ACCESS (READ_LATENCY=1, mid-cycle) -> all outputs 0 immediately, no resp_valid afterwards, and req_ready=1 once rst deasserts.
- SB addr=0x1003 wdata=0x000000A5 -> bus_mem_write one cycle, byteen=4'b1000, bus_wdata=0xA5A5A5A5, resp_valid at T+2, resp_err=0.
- LB addr=0x1002 with bus_rdata=0x12F03456 -> byteen=4'b0100, bus_mem_read 2 cycles, resp_rdata=0xFFFFFFF0 at T+3; repeat as LBU -> 0x000000F0.
- LH addr=0x1002 with bus_rdata=0x8001ABCD -> resp_rdata=0xFFFF8001. Then SH addr=0x1002 wdata=0x1234 -> byteen=4'b1100, bus_wdata=0x12341234.
- LW addr=0x1001 -> no bus strobes, resp_valid at T+1 with resp_err=1 and rdata=0. Store funct3=3'b100 -> same error response.
- Back-to-back: req_valid held high with SW then LW -> second accepted only the cycle after the first RESP. req_ready=0 throughout ACCESS and RESP. Strobes never overlap.
